// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with start/done handshake, remainder output,
// per-operation signed/unsigned mode, and divide-by-zero / overflow reporting.
module seq_divider #(
    parameter int DEVIDENT_LENGTH = 10,
    parameter int DIVISOR_LENGTH  = 5
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic                       Start,
    input  logic                       Signed,
    input  logic [DEVIDENT_LENGTH-1:0] OperA,
    input  logic [DIVISOR_LENGTH-1:0]  OperD,
    output logic                       Busy,
    output logic                       Done,
    output logic [DEVIDENT_LENGTH-1:0] Quotient,
    output logic [DIVISOR_LENGTH-1:0]  Remainder,
    output logic                       DivByZero,
    output logic                       Overflow
);

    localparam int N  = DEVIDENT_LENGTH;
    localparam int M  = DIVISOR_LENGTH;
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] bitCnt;
    logic [N-1:0]  dvdReg;     // holds |A| on entry, shifts into the quotient
    logic [M-1:0]  divReg;     // |D|
    logic [M:0]    remReg;     // partial remainder
    logic          negQuot;
    logic          negRem;
    logic          zeroReg;
    logic          ovfReg;

    logic          aNeg;
    logic          dNeg;
    logic [N-1:0]  aAbs;
    logic [M-1:0]  dAbs;
    logic          ovfDetect;
    logic [M:0]    shifted;
    logic [M+1:0]  trial;
    logic          qBit;
    logic [N-1:0]  quotFinal;
    logic [M-1:0]  remFinal;

    assign aNeg      = Signed & OperA[N-1];
    assign dNeg      = Signed & OperD[M-1];
    assign aAbs      = aNeg ? -OperA : OperA;
    assign dAbs      = dNeg ? -OperD : OperD;
    assign ovfDetect = Signed && (OperA == {1'b1, {(N-1){1'b0}}}) && (OperD == '1);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        shifted   = {remReg[M-1:0], dvdReg[N-1]};
        trial     = {1'b0, shifted} - {2'b00, divReg};
        qBit      = ~trial[M+1];
        quotFinal = negQuot ? -dvdReg : dvdReg;
        remFinal  = negRem ? -remReg[M-1:0] : remReg[M-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            bitCnt    <= '0;
            dvdReg    <= '0;
            divReg    <= '0;
            remReg    <= '0;
            negQuot   <= 1'b0;
            negRem    <= 1'b0;
            zeroReg   <= 1'b0;
            ovfReg    <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        dvdReg  <= aAbs;
                        divReg  <= dAbs;
                        remReg  <= '0;
                        bitCnt  <= '0;
                        negQuot <= aNeg ^ dNeg;
                        negRem  <= aNeg;
                        zeroReg <= (OperD == '0);
                        ovfReg  <= ovfDetect;
                        Busy    <= 1'b1;
                        state   <= (OperD == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    dvdReg <= {dvdReg[N-2:0], qBit};
                    remReg <= qBit ? trial[M:0] : shifted;
                    bitCnt <= bitCnt + 1'b1;
                    if (bitCnt == CW'(N-1))
                        state <= FIX;
                end
                FIX: begin
                    // Zero divisor bypasses CALC, so the datapath registers are not meaningful here.
                    Quotient  <= zeroReg ? '1 : quotFinal;
                    Remainder <= zeroReg ? '0 : remFinal;
                    DivByZero <= zeroReg;
                    Overflow  <= ovfReg;
                    Busy      <= 1'b0;
                    Done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, handshake scenarios and
// randomized operations against an integer-arithmetic reference model.
module tb_seq_divider;

    localparam int N = 10;
    localparam int M = 5;
    localparam int MASK_N = (1 << N) - 1;
    localparam int MASK_M = (1 << M) - 1;

    logic         CLK = 1'b0;
    logic         RST_n = 1'b0;
    logic         Start = 1'b0;
    logic         Signed = 1'b0;
    logic [N-1:0] OperA = '0;
    logic [M-1:0] OperD = '0;
    logic         Busy;
    logic         Done;
    logic [N-1:0] Quotient;
    logic [M-1:0] Remainder;
    logic         DivByZero;
    logic         Overflow;

    seq_divider #(.DEVIDENT_LENGTH(N), .DIVISOR_LENGTH(M)) dut (
        .CLK(CLK), .RST_n(RST_n), .Start(Start), .Signed(Signed),
        .OperA(OperA), .OperD(OperD), .Busy(Busy), .Done(Done),
        .Quotient(Quotient), .Remainder(Remainder),
        .DivByZero(DivByZero), .Overflow(Overflow)
    );

    always #5 CLK = ~CLK;

    int errs = 0;
    int checks = 0;
    int edgeCnt = 0;
    int expQ, expR, expZ, expV;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division (SV '/' and '%' truncate toward zero).
    function automatic void model(input int a, input int d, input bit s);
        int sa = a;
        int sd = d;
        if (s && a >= (1 << (N-1))) sa = a - (1 << N);
        if (s && d >= (1 << (M-1))) sd = d - (1 << M);
        expZ = 0;
        expV = 0;
        if (d == 0) begin
            expQ = MASK_N; expR = 0; expZ = 1;
        end else if (s && sa == -(1 << (N-1)) && sd == -1) begin
            expQ = 1 << (N-1); expR = 0; expV = 1;
        end else if (s) begin
            expQ = (sa / sd) & MASK_N;
            expR = (sa % sd) & MASK_M;
        end else begin
            expQ = (a / d) & MASK_N;
            expR = (a % d) & MASK_M;
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        edgeCnt++;
    endtask

    // Presents an operation for one edge, then scrambles the operand inputs.
    task automatic launch(input int a, input int d, input bit s);
        model(a, d, s);
        OperA  = N'(a);
        OperD  = M'(d);
        Signed = s;
        Start  = 1'b1;
        edgeCnt = 0;
        tick();
        Start  = 1'b0;
        OperA  = N'($urandom);
        OperD  = M'($urandom);
        Signed = 1'($urandom);
        check("busy_after_accept", 32'(Busy), 32'd1);
    endtask

    task automatic waitDone(input string tag);
        while (Done !== 1'b1 && edgeCnt < 40) tick();
        check({tag, "_latency"}, edgeCnt, expZ ? 2 : N + 2);
        check({tag, "_q"}, 32'(Quotient), expQ);
        check({tag, "_r"}, 32'(Remainder), expR);
        check({tag, "_dz"}, 32'(DivByZero), expZ);
        check({tag, "_ovf"}, 32'(Overflow), expV);
        check({tag, "_busy_at_done"}, 32'(Busy), 32'd0);
    endtask

    task automatic runOp(input string tag, input int a, input int d, input bit s);
        launch(a, d, s);
        waitDone(tag);
    endtask

    initial begin
        int doneSeen;
        // Reset state
        tick();
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_q", 32'(Quotient), 0);
        check("rst_r", 32'(Remainder), 0);
        check("rst_flags", {30'd0, DivByZero, Overflow}, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        tick();

        // Unsigned
        runOp("u21_7", 21, 7, 0);
        tick();
        check("done_pulse_width", 32'(Done), 0);
        tick();
        check("hold_q", 32'(Quotient), expQ);
        runOp("u1000_7", 1000, 7, 0);
        runOp("u1023_31", 1023, 31, 0);
        runOp("u1_1", 1, 1, 0);

        // Signed
        runOp("s-22_7", 'h3EA, 7, 1);
        runOp("s22_-7", 22, 'h19, 1);
        runOp("s-21_-7", 'h3EB, 'h19, 1);

        // Divide by zero, then cleared by the next operation
        runOp("u12_0", 12, 0, 0);
        runOp("u12_3", 12, 3, 0);
        runOp("s12_0", 12, 0, 1);
        runOp("s_ovf", 'h200, 'h1F, 1);
        runOp("s_after_ovf", 'h200, 'h01, 1);

        // Start mid-CALC is ignored
        launch(1000, 7, 0);
        repeat (3) tick();
        Start = 1'b1; OperA = N'(5); OperD = M'(1);
        tick();
        Start = 1'b0;
        waitDone("ignore_mid");

        // Back-to-back: next launch lands in the Done cycle
        launch(500, 9, 0);
        waitDone("b2b_first");
        launch(777, 13, 0);
        waitDone("b2b_second");

        // Reset mid-CALC
        launch(100, 3, 0);
        repeat (4) tick();
        RST_n = 1'b0;
        #1;
        check("abort_busy", 32'(Busy), 0);
        check("abort_q", 32'(Quotient), 0);
        check("abort_r", 32'(Remainder), 0);
        @(negedge CLK);
        RST_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < N + 4; i++) begin
            tick();
            if (Done === 1'b1) doneSeen++;
        end
        check("abort_no_done", doneSeen, 0);
        runOp("after_abort", 999, 10, 0);

        // Randomized
        for (int i = 0; i < 150; i++) begin
            int a = int'($urandom_range(0, MASK_N));
            int d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, MASK_M));
            bit s = 1'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                a = 'h200; d = 'h1F; s = 1'b1;
            end
            runOp("rand", a, d, s);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
